// File: rtl/shift_pkg.sv
// Shared constants and input-FSM encoding for the serial-to-parallel deserializer.
package shift_pkg;
  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;
endpackage

// File: rtl/shift_deserializer_if.sv
// Serial input, consumer handshake and status signals of the deserializer.
interface shift_deserializer_if import shift_pkg::*; #(
  parameter int WIDTH = DEFAULT_WIDTH
);
  logic                     enable;
  logic                     sync;
  logic                     serialIn;
  logic                     dataReady;
  logic [WIDTH-1:0]         dataOut;
  logic                     dataValid;
  logic                     overrun;
  logic [$clog2(WIDTH):0]   bitCount;

  modport slave (
    input  enable, sync, serialIn, dataReady,
    output dataOut, dataValid, overrun, bitCount
  );

  modport master (
    output enable, sync, serialIn, dataReady,
    input  dataOut, dataValid, overrun, bitCount
  );
endinterface

// File: rtl/deser_out_buf.sv
// Output holding register: one-word buffer with valid/ready handshake and sticky overrun.
module deser_out_buf import shift_pkg::*; #(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] word,
  input  logic             ready,
  output logic [WIDTH-1:0] data,
  output logic             valid,
  output logic             overrun
);
  logic [WIDTH-1:0] data_p1;
  logic             vld_p1;
  logic             ovr_p1;

  // Output stage: a new word may replace the held one only if it is being consumed
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      data_p1 <= '0;
      vld_p1  <= 1'b0;
      ovr_p1  <= 1'b0;
    end else if (load) begin
      if (vld_p1 && !ready) begin
        ovr_p1 <= 1'b1;
      end else begin
        data_p1 <= word;
        vld_p1  <= 1'b1;
      end
    end else if (vld_p1 && ready) begin
      vld_p1 <= 1'b0;
    end
  end

  assign data    = data_p1;
  assign valid   = vld_p1;
  assign overrun = ovr_p1;
endmodule

// File: rtl/shift_deserializer.sv
// Serial-to-parallel deserializer: assembles WIDTH-bit words from a qualified bit stream.
module shift_deserializer import shift_pkg::*; #(
  parameter int WIDTH     = DEFAULT_WIDTH,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic               clk,
  input  logic               rst_n,
  shift_deserializer_if.slave bus
);
  localparam int            CW   = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH);

  state_t           state_p0, state_d;
  logic [CW-1:0]    cnt_p0, cnt_d;
  logic [WIDTH-1:0] shreg_p0, shreg_d;
  logic             done;
  logic [WIDTH-1:0] word;

  function automatic logic [WIDTH-1:0] shift_in(input logic [WIDTH-1:0] cur, input logic b);
    if (MSB_FIRST) return {cur[WIDTH-2:0], b};
    else           return {b, cur[WIDTH-1:1]};
  endfunction

  // Input stage: shift register, bit counter and FSM state
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_p0 <= IDLE;
      cnt_p0   <= '0;
      shreg_p0 <= '0;
    end else begin
      state_p0 <= state_d;
      cnt_p0   <= cnt_d;
      shreg_p0 <= shreg_d;
    end
  end

  always_comb begin
    state_d = state_p0;
    cnt_d   = cnt_p0;
    shreg_d = shreg_p0;
    done    = 1'b0;
    word    = shreg_p0;
    if (bus.enable) begin
      // sync restarts the word regardless of how many bits were already gathered
      if (bus.sync || state_p0 == IDLE) begin
        word  = shift_in('0, bus.serialIn);
        cnt_d = CW'(1);
      end else begin
        word  = shift_in(shreg_p0, bus.serialIn);
        cnt_d = cnt_p0 + 1'b1;
      end
      if (cnt_d == LAST) begin
        done    = 1'b1;
        cnt_d   = '0;
        state_d = IDLE;
        shreg_d = '0;
      end else begin
        state_d = SHIFT;
        shreg_d = word;
      end
    end
  end

  assign bus.bitCount = cnt_p0;

  deser_out_buf #(.WIDTH(WIDTH)) u_out_buf (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (done),
    .word    (word),
    .ready   (bus.dataReady),
    .data    (bus.dataOut),
    .valid   (bus.dataValid),
    .overrun (bus.overrun)
  );
endmodule

// File: doc/shift_deserializer.md
SHIFT_DESERIALIZER -- requirements
Module: shift_deserializer

Interface
REQ-001 SHALL have parameter WIDTH, default 8, giving the word width in bits (minimum 2).
REQ-002 SHALL have parameter MSB_FIRST, default 1: 1 means the first received bit lands in the word MSB; 0 means it lands in the LSB.
REQ-003 SHALL have port clk  input  1  single clock; all state changes on the rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, synchronous and active-low.
REQ-005 SHALL have port enable  input  1  serialIn holds a valid bit this cycle.
REQ-006 SHALL have port sync  input  1  when qualified by enable, the current bit is the first bit of a new word.
REQ-007 SHALL have port serialIn  input  1  serial data bit.
REQ-008 SHALL have port dataReady  input  1  consumer accepts dataOut this cycle.
REQ-009 SHALL have port dataOut  output  WIDTH  assembled parallel word.
REQ-010 SHALL have port dataValid  output  1  dataOut holds an unconsumed word.
REQ-011 SHALL have port overrun  output  1  sticky flag: a completed word was dropped.
REQ-012 SHALL have port bitCount  output  clog2(WIDTH)+1  number of bits in the current partial word.

Function
REQ-013 SHALL sample serialIn only on edges where enable=1; with enable=0, the shift register and bitCount SHALL hold.
REQ-014 SHALL shift left with the new bit entering at the LSB when MSB_FIRST=1, and shift right with the new bit entering at the MSB when MSB_FIRST=0.
REQ-015 SHALL implement the input state machine IDLE (bitCount=0) and SHIFT (0<bitCount<WIDTH): IDLE->SHIFT on the first qualified bit; SHIFT->IDLE on capture of bit WIDTH.
REQ-016 SHALL, on enable=1 with sync=1, discard any partial word and treat the current bit as bit 1, giving bitCount=1 after the edge.
REQ-017 SHALL ignore sync when enable=0.
REQ-018 SHALL, on the edge that captures bit WIDTH, load the complete word into dataOut and reset bitCount to 0; dataValid=1 SHALL appear in the cycle immediately after that edge (latency 1 clock from the last bit).
REQ-019 SHALL hold dataOut and dataValid stable while dataValid=1 and dataReady=0.
REQ-020 SHALL clear dataValid on an edge where dataValid=1 and dataReady=1, unless a new word completes on that same edge.
REQ-021 SHALL, when a word completes on the same edge as an acceptance, load the new word and keep dataValid=1 without setting overrun.
REQ-022 SHALL, when a word completes while dataValid=1 and dataReady=0, drop the new word, keep dataOut unchanged, and set overrun=1.
REQ-023 SHALL keep overrun asserted until reset.
REQ-024 SHALL leave dataOut at its last value when dataValid=0 (no clearing on acceptance).

Reset
REQ-025 SHALL, on any edge with rst_n=0, set dataOut=0, dataValid=0, overrun=0, bitCount=0, the shift register to 0, and the state to IDLE.
REQ-026 SHALL give reset priority over enable, sync and dataReady; a partial word in progress at reset SHALL be discarded.

Structure
REQ-027 SHALL place the default WIDTH constant and the IDLE/SHIFT state encoding in the shared package shift_pkg.
REQ-028 SHALL implement the output holding register, including the valid/ready and overrun logic, as the sub-module deser_out_buf.

Verification
REQ-029 SHALL cover: MSB_FIRST=1, sync on the first bit, bits 0,0,0,0,1,1,1,1 on consecutive cycles, dataReady=1 -> dataOut=0x0F with dataValid high for exactly 1 cycle, one cycle after the 8th bit.
REQ-030 SHALL cover: MSB_FIRST=0, the same bit sequence -> dataOut=0xF0.
REQ-031 SHALL cover: dataReady=0, words 0xA5 then 0x3C sent back-to-back -> dataOut stays 0xA5, dataValid=1, and overrun=1 from the cycle after the 16th bit.
REQ-032 SHALL cover: word 0x96 sent with enable alternating 1/0 -> bitCount holds during enable=0 cycles and dataOut=0x96.
REQ-033 SHALL cover: 3 bits sent, then sync=1 followed by word 0x5A -> dataOut=0x5A, with no word emitted for the partial bits.
REQ-034 SHALL cover: rst_n=0 for 1 cycle after 5 bits of a word -> all outputs 0; the next 8 bits (0xC3) produce dataOut=0xC3 with overrun=0; plus 5000 random cycles of enable, sync, serialIn and dataReady checked against a bit-accurate model.
